cva6_axi_timeout_guard: RTL and testbench

CVA6_AXI_TIMEOUT_GUARD -- requirements
Module: cva6_axi_timeout_guard

---
 rtl/cva6_axi_timeout_guard_pkg.sv | 64 ++++++
 rtl/cva6_axi_timeout_guard_fifo.sv | 63 ++++++
 rtl/cva6_axi_timeout_guard.sv | 220 ++++++++++++++++++++++
 tb/tb_cva6_axi_timeout_guard.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_axi_timeout_guard_pkg.sv
// Shared AXI4 types, response codes and guard state encoding for the CVA6 timeout guard.
package cva6_axi_timeout_guard_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_PASS    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_ISOLATE = 2'd2
    } guard_state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ax_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;

endpackage

// File: rtl/cva6_axi_timeout_guard_fifo.sv
// Outstanding-transaction FIFO holding {id, len} per accepted address beat.
module axi_id_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Push is allowed on a full FIFO only when a pop frees the slot in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push_i & (~full_o | pop_i);
        do_pop   = pop_i & ~empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; entries are only read when counted valid.
    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cva6_axi_timeout_guard.sv
// AXI4 timeout guard between CVA6 and the crossbar; one FSM per direction.
//
// state      | meaning
// PASS       | transparent pass-through, outstanding requests timed
// DRAIN      | slave abandoned; synthesize SLVERR responses for every outstanding request
// ISOLATE    | all drained; reject new requests and sink slave responses until clear_i
module cva6_axi_timeout_guard
    import cva6_axi_timeout_guard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned AXI_ID_WIDTH    = 4,
    parameter int unsigned AXI_ADDR_WIDTH  = 64,
    parameter int unsigned AXI_DATA_WIDTH  = 64
) (
    input  logic      clock_i,
    input  logic      reset_ni,
    input  axi_req_t  s_axi_req_i,
    output axi_resp_t s_axi_resp_o,
    output axi_req_t  m_axi_req_o,
    input  axi_resp_t m_axi_resp_i,
    input  logic      clear_i,
    output logic      rd_timeout_o,
    output logic      wr_timeout_o
);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT_CYCLES);
    localparam int unsigned ENT_W  = AXI_ID_WIDTH + 8;
    localparam int unsigned WCNT_W = $clog2(MAX_OUTSTANDING + 1) + 1;

    // The struct types are fixed by the package; the parameters must agree with them.
    if (AXI_ID_WIDTH != ID_W || AXI_ADDR_WIDTH != ADDR_W || AXI_DATA_WIDTH != DATA_W) begin : g_width_check
        $error("AXI width parameters do not match the package struct widths");
    end

    guard_state_e      rd_state_q, rd_state_d, wr_state_q, wr_state_d;
    logic [TMR_W-1:0]  rd_timer_q, rd_timer_d, wr_timer_q, wr_timer_d;
    logic [7:0]        rd_beat_q, rd_beat_d;
    logic [WCNT_W-1:0] wlast_cnt_q, wlast_cnt_d;
    logic              rd_flag_q, rd_flag_d, wr_flag_q, wr_flag_d;

    logic              rd_push, rd_pop, rd_full, rd_empty;
    logic              wr_push, wr_pop, wr_full, wr_empty;
    logic [ENT_W-1:0]  rd_head, wr_head;
    logic [ID_W-1:0]   rd_head_id, wr_head_id;
    logic [7:0]        rd_head_len, wr_head_len_unused;
    logic              r_hs, b_hs, rd_last, wr_b_ok, w_last_hs, wcnt_inc, wcnt_dec;

    assign {rd_head_id, rd_head_len}        = rd_head;
    assign {wr_head_id, wr_head_len_unused} = wr_head;
    assign rd_timeout_o = rd_flag_q;
    assign wr_timeout_o = wr_flag_q;

    axi_id_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(ENT_W)) i_rd_fifo (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .push_i  (rd_push),
        .pop_i   (rd_pop),
        .data_i  ({s_axi_req_i.ar.id, s_axi_req_i.ar.len}),
        .data_o  (rd_head),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

    axi_id_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(ENT_W)) i_wr_fifo (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .push_i  (wr_push),
        .pop_i   (wr_pop),
        .data_i  ({s_axi_req_i.aw.id, s_axi_req_i.aw.len}),
        .data_o  (wr_head),
        .full_o  (wr_full),
        .empty_o (wr_empty)
    );

    // Channel muxing, FIFO control, timers and next state for both directions.
    always_comb begin
        m_axi_req_o  = s_axi_req_i;
        s_axi_resp_o = m_axi_resp_i;
        rd_state_d   = rd_state_q;
        rd_timer_d   = rd_timer_q;
        rd_beat_d    = rd_beat_q;
        rd_flag_d    = rd_flag_q;
        wr_state_d   = wr_state_q;
        wr_timer_d   = wr_timer_q;
        wr_flag_d    = wr_flag_q;
        wlast_cnt_d  = wlast_cnt_q;
        rd_push      = 1'b0;
        rd_pop       = 1'b0;
        wr_push      = 1'b0;
        wr_pop       = 1'b0;
        r_hs         = m_axi_resp_i.r_valid & s_axi_req_i.r_ready;
        b_hs         = m_axi_resp_i.b_valid & s_axi_req_i.b_ready;
        rd_last      = (rd_beat_q == rd_head_len);
        wr_b_ok      = ~wr_empty & (wlast_cnt_q != '0);

        unique case (rd_state_q)
            ST_PASS: begin
                m_axi_req_o.ar_valid  = s_axi_req_i.ar_valid & ~rd_full;
                s_axi_resp_o.ar_ready = m_axi_resp_i.ar_ready & ~rd_full;
                rd_push = s_axi_req_i.ar_valid & m_axi_resp_i.ar_ready & ~rd_full;
                rd_pop  = r_hs & m_axi_resp_i.r.last;
                if (rd_empty || r_hs) rd_timer_d = '0;
                else if (rd_timer_q != TMO) rd_timer_d = rd_timer_q + TMR_W'(1);
                // A response in the expiry cycle counts as progress and cancels the abort.
                if (rd_timer_q == TMO && !r_hs && !rd_empty) begin
                    rd_state_d = ST_DRAIN;
                    rd_flag_d  = 1'b1;
                    rd_timer_d = '0;
                end
            end
            ST_DRAIN: begin
                m_axi_req_o.ar_valid  = 1'b0;
                m_axi_req_o.r_ready   = 1'b1;
                s_axi_resp_o.ar_ready = 1'b0;
                s_axi_resp_o.r_valid  = ~rd_empty;
                s_axi_resp_o.r.id     = rd_head_id;
                s_axi_resp_o.r.data   = '0;
                s_axi_resp_o.r.resp   = RESP_SLVERR;
                s_axi_resp_o.r.last   = rd_last;
                if (!rd_empty && s_axi_req_i.r_ready) begin
                    if (rd_last) begin
                        rd_pop    = 1'b1;
                        rd_beat_d = '0;
                    end else begin
                        rd_beat_d = rd_beat_q + 8'd1;
                    end
                end
                if (rd_empty) rd_state_d = ST_ISOLATE;
            end
            ST_ISOLATE: begin
                m_axi_req_o.ar_valid  = 1'b0;
                m_axi_req_o.r_ready   = 1'b1;
                s_axi_resp_o.ar_ready = 1'b0;
                s_axi_resp_o.r_valid  = 1'b0;
                if (clear_i) begin
                    rd_state_d = ST_PASS;
                    rd_flag_d  = 1'b0;
                    rd_timer_d = '0;
                    rd_beat_d  = '0;
                end
            end
            default: rd_state_d = ST_PASS;
        endcase

        unique case (wr_state_q)
            ST_PASS: begin
                m_axi_req_o.aw_valid  = s_axi_req_i.aw_valid & ~wr_full;
                s_axi_resp_o.aw_ready = m_axi_resp_i.aw_ready & ~wr_full;
                wr_push = s_axi_req_i.aw_valid & m_axi_resp_i.aw_ready & ~wr_full;
                wr_pop  = b_hs;
                if (wr_empty || b_hs) wr_timer_d = '0;
                else if (wr_timer_q != TMO) wr_timer_d = wr_timer_q + TMR_W'(1);
                if (wr_timer_q == TMO && !b_hs && !wr_empty) begin
                    wr_state_d = ST_DRAIN;
                    wr_flag_d  = 1'b1;
                    wr_timer_d = '0;
                end
            end
            ST_DRAIN: begin
                m_axi_req_o.aw_valid  = 1'b0;
                m_axi_req_o.w_valid   = 1'b0;
                m_axi_req_o.b_ready   = 1'b1;
                s_axi_resp_o.aw_ready = 1'b0;
                s_axi_resp_o.w_ready  = 1'b1;
                // B for the head waits until its data burst has been fully consumed.
                s_axi_resp_o.b_valid  = wr_b_ok;
                s_axi_resp_o.b.id     = wr_head_id;
                s_axi_resp_o.b.resp   = RESP_SLVERR;
                wr_pop = wr_b_ok & s_axi_req_i.b_ready;
                if (wr_empty) wr_state_d = ST_ISOLATE;
            end
            ST_ISOLATE: begin
                m_axi_req_o.aw_valid  = 1'b0;
                m_axi_req_o.w_valid   = 1'b0;
                m_axi_req_o.b_ready   = 1'b1;
                s_axi_resp_o.aw_ready = 1'b0;
                s_axi_resp_o.w_ready  = 1'b0;
                s_axi_resp_o.b_valid  = 1'b0;
                if (clear_i) begin
                    wr_state_d = ST_PASS;
                    wr_flag_d  = 1'b0;
                    wr_timer_d = '0;
                end
            end
            default: wr_state_d = ST_PASS;
        endcase

        // WLAST beats seen minus B responses retired; W may legally lead its AW.
        w_last_hs   = s_axi_req_i.w_valid & s_axi_resp_o.w_ready & s_axi_req_i.w.last;
        wcnt_inc    = w_last_hs & (wlast_cnt_q != '1);
        wcnt_dec    = wr_pop & (wlast_cnt_q != '0);
        wlast_cnt_d = wlast_cnt_q + WCNT_W'(wcnt_inc) - WCNT_W'(wcnt_dec);
        if (wr_state_q == ST_ISOLATE) wlast_cnt_d = '0;
    end

    // State, timer and counter registers.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            rd_state_q  <= ST_PASS;
            wr_state_q  <= ST_PASS;
            rd_timer_q  <= '0;
            wr_timer_q  <= '0;
            rd_beat_q   <= '0;
            wlast_cnt_q <= '0;
            rd_flag_q   <= 1'b0;
            wr_flag_q   <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            rd_timer_q  <= rd_timer_d;
            wr_timer_q  <= wr_timer_d;
            rd_beat_q   <= rd_beat_d;
            wlast_cnt_q <= wlast_cnt_d;
            rd_flag_q   <= rd_flag_d;
            wr_flag_q   <= wr_flag_d;
        end
    end

endmodule

// File: tb/tb_cva6_axi_timeout_guard.sv
// Scoreboard bench: stimulus pushes expected R/B beats, a negedge monitor pops and compares.
module tb_cva6_axi_timeout_guard;
    import cva6_axi_timeout_guard_pkg::*;

    localparam int TMO = 1024;

    logic      clock_i = 1'b0;
    logic      reset_ni;
    logic      clear_i;
    axi_req_t  req;
    axi_resp_t s_resp;
    axi_req_t  m_req;
    axi_resp_t sresp;
    logic      rd_timeout_o, wr_timeout_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    r_chan_t exp_r[$];
    b_chan_t exp_b[$];
    r_chan_t mon_r;
    b_chan_t mon_b;

    cva6_axi_timeout_guard dut (
        .clock_i     (clock_i),
        .reset_ni    (reset_ni),
        .s_axi_req_i (req),
        .s_axi_resp_o(s_resp),
        .m_axi_req_o (m_req),
        .m_axi_resp_i(sresp),
        .clear_i     (clear_i),
        .rd_timeout_o(rd_timeout_o),
        .wr_timeout_o(wr_timeout_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic exp_r_push(input logic [3:0] id, input logic [63:0] data,
                              input logic [1:0] resp, input logic last);
        r_chan_t e;
        e.id = id; e.data = data; e.resp = resp; e.last = last;
        exp_r.push_back(e);
    endtask

    task automatic exp_b_push(input logic [3:0] id, input logic [1:0] resp);
        b_chan_t e;
        e.id = id; e.resp = resp;
        exp_b.push_back(e);
    endtask

    // Slave returns one R beat; the guard in PASS must forward it unchanged.
    task automatic slave_r(input logic [3:0] id, input logic [63:0] data, input logic last);
        sresp.r_valid  = 1'b1;
        sresp.r.id     = id;
        sresp.r.data   = data;
        sresp.r.resp   = RESP_OKAY;
        sresp.r.last   = last;
        exp_r_push(id, data, RESP_OKAY, last);
        tick();
        sresp.r_valid  = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [7:0] len);
        req.ar_valid = 1'b1;
        req.ar.id    = id;
        req.ar.len   = len;
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic wait_flag(input bit wr, input int budget, output int cnt);
        cnt = 0;
        while ((wr ? wr_timeout_o : rd_timeout_o) !== 1'b1 && cnt < budget) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_drained(input string name, input int budget);
        int k = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        chk(name, 64'(exp_r.size() + exp_b.size()), 64'd0);
    endtask

    // Monitor: every response beat presented to the master must match the scoreboard head.
    always @(negedge clock_i) begin
        if (reset_ni === 1'b1) begin
            if (s_resp.r_valid && req.r_ready) begin
                if (exp_r.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL r_unexpected: got id %0d resp %0d last %0d, required no beat",
                             s_resp.r.id, s_resp.r.resp, s_resp.r.last);
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("r_id",   64'(s_resp.r.id),   64'(mon_r.id));
                    chk("r_data", s_resp.r.data,      mon_r.data);
                    chk("r_resp", 64'(s_resp.r.resp), 64'(mon_r.resp));
                    chk("r_last", 64'(s_resp.r.last), 64'(mon_r.last));
                end
            end
            if (s_resp.b_valid && req.b_ready) begin
                if (exp_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_unexpected: got id %0d resp %0d, required no beat",
                             s_resp.b.id, s_resp.b.resp);
                end else begin
                    mon_b = exp_b.pop_front();
                    chk("b_id",   64'(s_resp.b.id),   64'(mon_b.id));
                    chk("b_resp", 64'(s_resp.b.resp), 64'(mon_b.resp));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req      = '0;
        sresp    = '0;
        clear_i  = 1'b0;
        reset_ni = 1'b0;
        req.r_ready = 1'b1;
        req.b_ready = 1'b1;
        repeat (3) tick();
        reset_ni = 1'b1;
        sresp.ar_ready = 1'b1;
        sresp.aw_ready = 1'b1;
        sresp.w_ready  = 1'b1;
        #1;
        chk("reset_rd_flag",   64'(rd_timeout_o),    64'd0);
        chk("reset_wr_flag",   64'(wr_timeout_o),    64'd0);
        chk("reset_ar_ready",  64'(s_resp.ar_ready), 64'd1);
        chk("reset_r_valid",   64'(s_resp.r_valid),  64'd0);
        chk("reset_rd_timer",  64'(dut.rd_timer_q),  64'd0);

        // Normal read: ID 3, 4 beats answered promptly.
        req.ar_valid = 1'b1; req.ar.id = 4'd3; req.ar.len = 8'd3;
        #1;
        chk("pass_ar_valid", 64'(m_req.ar_valid), 64'd1);
        chk("pass_ar_id",    64'(m_req.ar.id),    64'd3);
        tick();
        req.ar_valid = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) slave_r(4'd3, 64'hA0 + 64'(i), i == 3);
        wait_drained("read_pass_drained", 10);
        chk("read_pass_flag", 64'(rd_timeout_o), 64'd0);

        // Read timeout: ID 5, 2 beats, slave silent.
        send_ar(4'd5, 8'd1);
        exp_r_push(4'd5, 64'd0, RESP_SLVERR, 1'b0);
        exp_r_push(4'd5, 64'd0, RESP_SLVERR, 1'b1);
        wait_flag(1'b0, 2000, n);
        chk("rd_timeout_latency", 64'(n), 64'd1025);
        wait_drained("rd_drain_beats", 20);
        repeat (2) tick();
        req.ar_valid = 1'b1; req.ar.id = 4'd1; req.ar.len = 8'd0;
        sresp.r_valid = 1'b1; sresp.r.id = 4'd5; sresp.r.last = 1'b1;
        #1;
        chk("iso_rd_flag",     64'(rd_timeout_o),    64'd1);
        chk("iso_ar_ready",    64'(s_resp.ar_ready), 64'd0);
        chk("iso_ar_valid",    64'(m_req.ar_valid),  64'd0);
        chk("iso_r_ready",     64'(m_req.r_ready),   64'd1);
        chk("iso_r_valid",     64'(s_resp.r_valid),  64'd0);
        tick();
        req.ar_valid = 1'b0;
        sresp.r_valid = 1'b0;

        // Clear from ISOLATE, then a new AR passes through.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        req.ar_valid = 1'b1; req.ar.id = 4'd9; req.ar.len = 8'd0;
        #1;
        chk("clear_rd_flag",  64'(rd_timeout_o),    64'd0);
        chk("clear_ar_ready", 64'(s_resp.ar_ready), 64'd1);
        chk("clear_ar_id",    64'(m_req.ar.id),     64'd9);
        tick();
        req.ar_valid = 1'b0;
        slave_r(4'd9, 64'h99, 1'b1);
        wait_drained("clear_read_drained", 10);

        // Write timeout: AW IDs 1, 2, 7 with their data, no B.
        req.aw_valid = 1'b1; req.aw.len = 8'd0;
        req.aw.id = 4'd1; tick();
        req.aw.id = 4'd2; tick();
        req.aw.id = 4'd7; tick();
        req.aw_valid = 1'b0;
        req.w_valid = 1'b1; req.w.last = 1'b1; req.w.strb = '1;
        for (int i = 0; i < 3; i++) begin
            req.w.data = 64'hD0 + 64'(i);
            tick();
        end
        req.w_valid = 1'b0;
        exp_b_push(4'd1, RESP_SLVERR);
        exp_b_push(4'd2, RESP_SLVERR);
        exp_b_push(4'd7, RESP_SLVERR);
        wait_flag(1'b1, 2000, n);
        chk("wr_timeout_latency", 64'(n), 64'd1020);
        wait_drained("wr_drain_b", 20);
        repeat (2) tick();
        req.aw_valid = 1'b1; req.aw.id = 4'd4;
        #1;
        chk("iso_aw_ready", 64'(s_resp.aw_ready), 64'd0);
        chk("iso_aw_valid", 64'(m_req.aw_valid),  64'd0);
        chk("iso_wr_flag",  64'(wr_timeout_o),    64'd1);
        chk("iso_rd_indep", 64'(rd_timeout_o),    64'd0);
        tick();
        req.aw_valid = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        #1;
        chk("clear_wr_flag", 64'(wr_timeout_o), 64'd0);

        // FIFO full: 8 ARs outstanding stall the 9th until one RLAST.
        for (int i = 0; i < 8; i++) send_ar(4'(i), 8'd0);
        req.ar_valid = 1'b1; req.ar.id = 4'd8; req.ar.len = 8'd0;
        #1;
        chk("full_ar_ready", 64'(s_resp.ar_ready), 64'd0);
        chk("full_ar_valid", 64'(m_req.ar_valid),  64'd0);
        sresp.r_valid = 1'b1; sresp.r.id = 4'd0; sresp.r.data = 64'h10;
        sresp.r.resp = RESP_OKAY; sresp.r.last = 1'b1;
        exp_r_push(4'd0, 64'h10, RESP_OKAY, 1'b1);
        #1;
        chk("full_pop_cycle_ready", 64'(s_resp.ar_ready), 64'd0);
        tick();
        sresp.r_valid = 1'b0;
        #1;
        chk("full_next_ready", 64'(s_resp.ar_ready), 64'd1);
        tick();
        req.ar_valid = 1'b0;
        for (int i = 1; i < 9; i++) slave_r(4'(i), 64'h10 + 64'(i), 1'b1);
        wait_drained("full_drained", 10);
        chk("full_rd_flag", 64'(rd_timeout_o), 64'd0);

        // Response in the same cycle the timer expires wins.
        send_ar(4'd4, 8'd0);
        n = 0;
        while (dut.rd_timer_q != 11'(TMO) && n < 1100) begin
            tick();
            n++;
        end
        chk("race_timer_reach", 64'(n), 64'd1024);
        slave_r(4'd4, 64'h44, 1'b1);
        chk("race_timer_zero", 64'(dut.rd_timer_q), 64'd0);
        chk("race_no_abort",   64'(rd_timeout_o),   64'd0);
        repeat (3) tick();
        chk("race_still_pass", 64'(rd_timeout_o), 64'd0);
        wait_drained("race_drained", 5);

        // Reset in the middle of a read drain: no further SLVERR beats.
        send_ar(4'd6, 8'd7);
        wait_flag(1'b0, 2000, n);
        reset_ni = 1'b0;
        chk("drain2_latency", 64'(n), 64'd1025);
        repeat (2) tick();
        reset_ni = 1'b1;
        repeat (20) tick();
        chk("post_reset_flag",    64'(rd_timeout_o),   64'd0);
        chk("post_reset_r_valid", 64'(s_resp.r_valid), 64'd0);
        wait_drained("final_drained", 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
